// File: rtl/measure_pkg.sv
// Shared constants, types and helpers for the XGMII RX latency probe.
package measure_pkg;

   localparam int unsigned DATA_W       = 64;
   localparam int unsigned CTRL_W       = 8;
   localparam int unsigned LANES        = 8;
   localparam int unsigned LANE_IDX_W   = 3;
   localparam int unsigned WIDX_W       = 3;
   localparam int unsigned FBYTES_W     = 16;
   localparam int unsigned FBYTES_SUM_W = FBYTES_W + 1;
   localparam int unsigned CNT_W        = 32;
   localparam int unsigned CNT_SUM_W    = CNT_W + 1;
   localparam int unsigned TS_W         = 32;
   localparam int unsigned IP_W         = 32;

   localparam logic [7:0]  XGMII_START = 8'hFB;
   localparam logic [7:0]  XGMII_TERM  = 8'hFD;
   localparam logic [7:0]  XGMII_IDLE  = 8'h07;
   localparam logic [7:0]  XGMII_ERR   = 8'hFE;
   localparam logic [15:0] ETYPE_IPV4  = 16'h0800;
   localparam logic [7:0]  IPPROTO_UDP = 8'h11;

   // Header word indices (word 0 carries start/preamble/SFD)
   localparam logic [WIDX_W-1:0] WIDX_ETYPE   = 3'd2;
   localparam logic [WIDX_W-1:0] WIDX_PROTO   = 3'd3;
   localparam logic [WIDX_W-1:0] WIDX_IP_HI   = 3'd4;
   localparam logic [WIDX_W-1:0] WIDX_IP_LO   = 3'd5;
   localparam logic [WIDX_W-1:0] WIDX_MAGIC   = 3'd6;
   localparam logic [WIDX_W-1:0] WIDX_TS_LO   = 3'd7;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_HDR     = 2'd1,
      ST_PAYLOAD = 2'd2
   } rx_state_e;

   // One XGMII beat: per-lane control flags plus data, lane 0 in the low byte
   typedef struct packed {
      logic [CTRL_W-1:0] ctrl;
      logic [DATA_W-1:0] data;
   } xgmii_word_t;

   // Saturating add for the per-frame byte count
   function automatic logic [FBYTES_W-1:0] fb_sat_add(input logic [FBYTES_W-1:0] a,
                                                      input logic [3:0]          b);
      logic [FBYTES_W:0] s;
      s = {1'b0, a} + FBYTES_SUM_W'(b);
      return s[FBYTES_W] ? {FBYTES_W{1'b1}} : s[FBYTES_W-1:0];
   endfunction

   // Saturating add for the window counters
   function automatic logic [CNT_W-1:0] cnt_sat_add(input logic [CNT_W-1:0] a,
                                                    input logic [CNT_W-1:0] b);
      logic [CNT_W:0] s;
      s = {1'b0, a} + {1'b0, b};
      return s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
   endfunction

endpackage

// File: rtl/xgmii_rx_align.sv
// Realigns lane-4 starts onto lane 0 so the parser only ever sees lane-0 frames.
module xgmii_rx_align
   import measure_pkg::*;
(
   input  logic              sys_clk,
   input  logic              sys_rst_n,
   input  logic [DATA_W-1:0] rxd,
   input  logic [CTRL_W-1:0] rxc,
   output xgmii_word_t       aln
);

   localparam int unsigned HALF_D = DATA_W / 2;
   localparam int unsigned HALF_C = CTRL_W / 2;

   logic [HALF_D-1:0] hold_d_q;
   logic [HALF_C-1:0] hold_c_q;
   logic              shift_q;
   logic              start_l0_c;
   logic              start_l4_c;
   logic              use_shift_c;

   // Start detection; a lane-0 start forces the direct path for its own word
   always_comb begin
      start_l0_c  = rxc[0] && (rxd[7:0] == XGMII_START);
      start_l4_c  = rxc[HALF_C] && (rxd[HALF_D +: 8] == XGMII_START);
      use_shift_c = shift_q && !start_l0_c;
   end

   // Upper-half holding register, alignment mode and registered output word
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         hold_d_q <= {(HALF_D/8){XGMII_IDLE}};
         hold_c_q <= {HALF_C{1'b1}};
         shift_q  <= 1'b0;
         aln.data <= {LANES{XGMII_IDLE}};
         aln.ctrl <= {CTRL_W{1'b1}};
      end else begin
         hold_d_q <= rxd[DATA_W-1:HALF_D];
         hold_c_q <= rxc[CTRL_W-1:HALF_C];
         if (start_l4_c) begin
            shift_q <= 1'b1;
         end else if (start_l0_c) begin
            shift_q <= 1'b0;
         end
         if (use_shift_c) begin
            aln.data <= {rxd[HALF_D-1:0], hold_d_q};
            aln.ctrl <= {rxc[HALF_C-1:0], hold_c_q};
         end else begin
            aln.data <= rxd;
            aln.ctrl <= rxc;
         end
      end
   end

endmodule

// File: rtl/xgmii_rx_latency_probe.sv
// Parses the XGMII RX stream, matches generator UDP frames and reports
// latency plus per-window frame and byte counts.
module xgmii_rx_latency_probe
   import measure_pkg::*;
#(
   parameter logic [39:0] MAGIC_CODE = 40'hA5_5A_C3_3C_96,
   parameter int unsigned LAT_W      = 24
) (
   input  logic              sys_clk,
   input  logic              sys_rst_n,
   input  logic              sec_oneshot,
   input  logic [TS_W-1:0]   global_counter,
   input  logic [DATA_W-1:0] xgmii_rxd,
   input  logic [CTRL_W-1:0] xgmii_rxc,
   output logic [CNT_W-1:0]  rx_pps,
   output logic [CNT_W-1:0]  rx_throughput,
   output logic [LAT_W-1:0]  rx_latency,
   output logic [IP_W-1:0]   rx_ipv4_ip,
   output logic              rx_frame_valid
);

   xgmii_word_t           aln;
   logic [7:0]            lane_c [LANES];

   rx_state_e             state_q, state_d;
   logic [WIDX_W-1:0]     widx_q, widx_d;
   logic                  match_q, match_d;
   logic [FBYTES_W-1:0]   fbytes_q, fbytes_d;
   logic [IP_W-1:0]       dstip_q, dstip_d;
   logic [TS_W-1:0]       ts_q, ts_d;

   logic                  start_c;
   logic                  term_hit_c;
   logic [LANE_IDX_W-1:0] term_lane_c;
   logic [LANES-1:0]      pre_term_c;
   logic                  abort_c;
   logic                  commit_c;
   logic [FBYTES_W-1:0]   frame_bytes_c;
   logic [TS_W-1:0]       diff_c;
   logic [LAT_W-1:0]      lat_c;
   logic [CNT_W-1:0]      win_frames_q;
   logic [CNT_W-1:0]      win_bytes_q;

   xgmii_rx_align u_align (
      .sys_clk   (sys_clk),
      .sys_rst_n (sys_rst_n),
      .rxd       (xgmii_rxd),
      .rxc       (xgmii_rxc),
      .aln       (aln)
   );

   // Lane decode: start, first terminate, and stray control/error characters
   always_comb begin
      term_hit_c  = 1'b0;
      term_lane_c = '0;
      pre_term_c  = '0;
      abort_c     = 1'b0;
      for (int i = 0; i < int'(LANES); i++) begin
         lane_c[i] = aln.data[8*i +: 8];
      end
      start_c = aln.ctrl[0] && (lane_c[0] == XGMII_START);
      for (int i = int'(LANES) - 1; i >= 0; i--) begin
         if (aln.ctrl[i] && (lane_c[i] == XGMII_TERM)) begin
            term_hit_c  = 1'b1;
            term_lane_c = LANE_IDX_W'(i);
         end
      end
      for (int i = 0; i < int'(LANES); i++) begin
         pre_term_c[i] = !term_hit_c || (LANE_IDX_W'(i) < term_lane_c);
         if (aln.ctrl[i] && (lane_c[i] == XGMII_ERR)) begin
            abort_c = 1'b1;
         end
      end
      if ((aln.ctrl & pre_term_c) != '0) begin
         abort_c = 1'b1;
      end
   end

   // Header FSM state register
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state, header checks/captures and commit decision
   always_comb begin
      state_d       = state_q;
      widx_d        = widx_q;
      match_d       = match_q;
      fbytes_d      = fbytes_q;
      dstip_d       = dstip_q;
      ts_d          = ts_q;
      commit_c      = 1'b0;
      frame_bytes_c = fb_sat_add(fbytes_q, {1'b0, term_lane_c});
      case (state_q)
         ST_IDLE: begin
            if (start_c) begin
               state_d  = ST_HDR;
               widx_d   = 3'd1;
               match_d  = 1'b1;
               fbytes_d = '0;
            end
         end
         ST_HDR, ST_PAYLOAD: begin
            if (start_c) begin
               state_d  = ST_HDR;
               widx_d   = 3'd1;
               match_d  = 1'b1;
               fbytes_d = '0;
            end else if (abort_c) begin
               state_d = ST_IDLE;
            end else if (term_hit_c) begin
               // A terminate while still in the header is a runt
               state_d  = ST_IDLE;
               commit_c = (state_q == ST_PAYLOAD) && match_q;
            end else begin
               fbytes_d = fb_sat_add(fbytes_q, 4'd8);
               if (state_q == ST_HDR) begin
                  case (widx_q)
                     WIDX_ETYPE: begin
                        if ({lane_c[6], lane_c[7]} != ETYPE_IPV4) match_d = 1'b0;
                     end
                     WIDX_PROTO: begin
                        if (lane_c[7] != IPPROTO_UDP) match_d = 1'b0;
                     end
                     WIDX_IP_HI: dstip_d[31:16] = {lane_c[6], lane_c[7]};
                     WIDX_IP_LO: dstip_d[15:0]  = {lane_c[0], lane_c[1]};
                     WIDX_MAGIC: begin
                        if ({lane_c[2], lane_c[3], lane_c[4], lane_c[5], lane_c[6]} != MAGIC_CODE) begin
                           match_d = 1'b0;
                        end
                        ts_d[31:24] = lane_c[7];
                     end
                     WIDX_TS_LO: ts_d[23:0] = {lane_c[0], lane_c[1], lane_c[2]};
                     default: ;
                  endcase
                  if (widx_q == WIDX_TS_LO) begin
                     state_d = ST_PAYLOAD;
                  end else begin
                     widx_d = widx_q + 3'd1;
                  end
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Per-frame tracking registers
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         widx_q   <= '0;
         match_q  <= 1'b0;
         fbytes_q <= '0;
         dstip_q  <= '0;
         ts_q     <= '0;
      end else begin
         widx_q   <= widx_d;
         match_q  <= match_d;
         fbytes_q <= fbytes_d;
         dstip_q  <= dstip_d;
         ts_q     <= ts_d;
      end
   end

   // Wrap-safe latency with saturation to the reported width
   always_comb begin
      diff_c = global_counter - ts_q;
      lat_c  = ((diff_c >> LAT_W) != '0) ? {LAT_W{1'b1}} : diff_c[LAT_W-1:0];
   end

   // Commit outputs and one-second window counters
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         rx_frame_valid <= 1'b0;
         rx_latency     <= '0;
         rx_ipv4_ip     <= '0;
         rx_pps         <= '0;
         rx_throughput  <= '0;
         win_frames_q   <= '0;
         win_bytes_q    <= '0;
      end else begin
         rx_frame_valid <= commit_c;
         if (commit_c) begin
            rx_latency <= lat_c;
            rx_ipv4_ip <= dstip_q;
         end
         if (sec_oneshot) begin
            rx_pps        <= win_frames_q;
            rx_throughput <= win_bytes_q;
            win_frames_q  <= commit_c ? CNT_W'(1) : '0;
            win_bytes_q   <= commit_c ? CNT_W'(frame_bytes_c) : '0;
         end else if (commit_c) begin
            win_frames_q <= cnt_sat_add(win_frames_q, CNT_W'(1));
            win_bytes_q  <= cnt_sat_add(win_bytes_q, CNT_W'(frame_bytes_c));
         end
      end
   end

endmodule

// File: tb/tb_xgmii_rx_latency_probe.sv
// Directed bench for the XGMII RX latency probe.
`timescale 1ns/1ps
module tb_xgmii_rx_latency_probe;

   logic        sys_clk = 1'b0;
   logic        sys_rst_n = 1'b0;
   logic        sec_oneshot = 1'b0;
   logic [31:0] global_counter = 32'h0;
   logic [63:0] xgmii_rxd = {8{8'h07}};
   logic [7:0]  xgmii_rxc = 8'hFF;
   logic [31:0] rx_pps;
   logic [31:0] rx_throughput;
   logic [23:0] rx_latency;
   logic [31:0] rx_ipv4_ip;
   logic        rx_frame_valid;

   int checks = 0;
   int errors = 0;
   int pulse_cnt = 0;

   logic [63:0] wq_d[$];
   logic [7:0]  wq_c[$];

   localparam logic [39:0] MAGIC = 40'hA55AC33C96;

   xgmii_rx_latency_probe #(
      .MAGIC_CODE (40'hA5_5A_C3_3C_96),
      .LAT_W      (24)
   ) dut (
      .sys_clk        (sys_clk),
      .sys_rst_n      (sys_rst_n),
      .sec_oneshot    (sec_oneshot),
      .global_counter (global_counter),
      .xgmii_rxd      (xgmii_rxd),
      .xgmii_rxc      (xgmii_rxc),
      .rx_pps         (rx_pps),
      .rx_throughput  (rx_throughput),
      .rx_latency     (rx_latency),
      .rx_ipv4_ip     (rx_ipv4_ip),
      .rx_frame_valid (rx_frame_valid)
   );

   always #3 sys_clk = ~sys_clk;

   always @(negedge sys_clk) if (rx_frame_valid === 1'b1) pulse_cnt++;

   // corrupt: 0 none, 1 magic byte flipped, 2 EtherType 86DD, 3 error char in word 5
   task automatic build_frame(input int lane_off, input int len, input logic [31:0] ts,
                              input logic [31:0] ip, input int corrupt);
      logic [7:0] f[$];
      logic [7:0] sb[$];
      logic       sc[$];
      logic [39:0] m;
      logic [63:0] d;
      logic [7:0]  c;
      m = MAGIC;
      for (int i = 0; i < 64; i++) f.push_back(8'(i * 7 + 3));
      f[14] = 8'h08; f[15] = 8'h00; f[23] = 8'h11;
      f[30] = ip[31:24]; f[31] = ip[23:16]; f[32] = ip[15:8]; f[33] = ip[7:0];
      f[42] = m[39:32]; f[43] = m[31:24]; f[44] = m[23:16]; f[45] = m[15:8]; f[46] = m[7:0];
      f[47] = ts[31:24]; f[48] = ts[23:16]; f[49] = ts[15:8]; f[50] = ts[7:0];
      if (corrupt == 1) f[42] = f[42] ^ 8'h01;
      if (corrupt == 2) begin f[14] = 8'h86; f[15] = 8'hDD; end
      while (f.size() > len) void'(f.pop_back());
      for (int i = 0; i < lane_off; i++) begin sb.push_back(8'h07); sc.push_back(1'b1); end
      sb.push_back(8'hFB); sc.push_back(1'b1);
      for (int i = 0; i < 6; i++) begin sb.push_back(8'h55); sc.push_back(1'b0); end
      sb.push_back(8'hD5); sc.push_back(1'b0);
      foreach (f[i]) begin sb.push_back(f[i]); sc.push_back(1'b0); end
      sb.push_back(8'hFD); sc.push_back(1'b1);
      if (corrupt == 3) begin sb[lane_off + 8 + 35] = 8'hFE; sc[lane_off + 8 + 35] = 1'b1; end
      while ((sb.size() % 8) != 0) begin sb.push_back(8'h07); sc.push_back(1'b1); end
      for (int i = 0; i < 8; i++) begin sb.push_back(8'h07); sc.push_back(1'b1); end
      for (int w = 0; w < sb.size() / 8; w++) begin
         for (int l = 0; l < 8; l++) begin
            d[8*l +: 8] = sb[8*w + l];
            c[l]        = sc[8*w + l];
         end
         wq_d.push_back(d);
         wq_c.push_back(c);
      end
   endtask

   task automatic drive_words(input int sec_at);
      int n;
      n = wq_d.size();
      for (int i = 0; i < n; i++) begin
         @(negedge sys_clk);
         xgmii_rxd   = wq_d.pop_front();
         xgmii_rxc   = wq_c.pop_front();
         sec_oneshot = (i == sec_at);
      end
      @(negedge sys_clk);
      xgmii_rxd   = {8{8'h07}};
      xgmii_rxc   = 8'hFF;
      sec_oneshot = 1'b0;
      repeat (4) @(negedge sys_clk);
   endtask

   task automatic close_window();
      @(negedge sys_clk);
      sec_oneshot = 1'b1;
      @(negedge sys_clk);
      sec_oneshot = 1'b0;
   endtask

   task automatic test_reset();
      sys_rst_n = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(negedge sys_clk);
         xgmii_rxd = {$urandom, $urandom};
         xgmii_rxc = 8'($urandom);
         checks++;
         if (rx_frame_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", rx_frame_valid); end
      end
      checks++; if (rx_pps !== 32'h0) begin errors++; $display("FAIL reset_pps: got %h expected 0", rx_pps); end
      checks++; if (rx_throughput !== 32'h0) begin errors++; $display("FAIL reset_thr: got %h expected 0", rx_throughput); end
      checks++; if (rx_latency !== 24'h0) begin errors++; $display("FAIL reset_lat: got %h expected 0", rx_latency); end
      checks++; if (rx_ipv4_ip !== 32'h0) begin errors++; $display("FAIL reset_ip: got %h expected 0", rx_ipv4_ip); end
      checks++; if (pulse_cnt !== 0) begin errors++; $display("FAIL reset_pulses: got %0d expected 0", pulse_cnt); end
      @(negedge sys_clk);
      xgmii_rxd = {8{8'h07}};
      xgmii_rxc = 8'hFF;
      sys_rst_n = 1'b1;
      repeat (2) @(negedge sys_clk);
   endtask

   task automatic test_lane0();
      int p0;
      close_window();
      global_counter = 32'h00001234;
      p0 = pulse_cnt;
      build_frame(0, 64, 32'h00001000, 32'hC0A80105, 0);
      drive_words(-1);
      checks++; if (pulse_cnt !== p0 + 1) begin errors++; $display("FAIL l0_pulse: got %0d expected %0d", pulse_cnt - p0, 1); end
      checks++; if (rx_latency !== 24'h000234) begin errors++; $display("FAIL l0_latency: got %h expected 000234", rx_latency); end
      checks++; if (rx_ipv4_ip !== 32'hC0A80105) begin errors++; $display("FAIL l0_ip: got %h expected c0a80105", rx_ipv4_ip); end
      close_window();
      checks++; if (rx_pps !== 32'd1) begin errors++; $display("FAIL l0_pps: got %0d expected 1", rx_pps); end
      checks++; if (rx_throughput !== 32'd64) begin errors++; $display("FAIL l0_thr: got %0d expected 64", rx_throughput); end
   endtask

   task automatic test_lane4_back_to_back();
      int p0;
      global_counter = 32'h00001234;
      p0 = pulse_cnt;
      build_frame(4, 64, 32'h00001000, 32'h0A000002, 0);
      drive_words(-1);
      checks++; if (pulse_cnt !== p0 + 1) begin errors++; $display("FAIL l4_pulse: got %0d expected 1", pulse_cnt - p0); end
      checks++; if (rx_latency !== 24'h000234) begin errors++; $display("FAIL l4_latency: got %h expected 000234", rx_latency); end
      checks++; if (rx_ipv4_ip !== 32'h0A000002) begin errors++; $display("FAIL l4_ip: got %h expected 0a000002", rx_ipv4_ip); end
      close_window();
      checks++; if (rx_pps !== 32'd1) begin errors++; $display("FAIL l4_pps: got %0d expected 1", rx_pps); end
      checks++; if (rx_throughput !== 32'd64) begin errors++; $display("FAIL l4_thr: got %0d expected 64", rx_throughput); end
      p0 = pulse_cnt;
      for (int i = 0; i < 10; i++) build_frame(0, 64, 32'h00001000, 32'h0A000000 + 32'(i), 0);
      drive_words(-1);
      checks++; if (pulse_cnt !== p0 + 10) begin errors++; $display("FAIL b2b_pulses: got %0d expected 10", pulse_cnt - p0); end
      checks++; if (rx_ipv4_ip !== 32'h0A000009) begin errors++; $display("FAIL b2b_ip: got %h expected 0a000009", rx_ipv4_ip); end
      close_window();
      checks++; if (rx_pps !== 32'd10) begin errors++; $display("FAIL b2b_pps: got %0d expected 10", rx_pps); end
      checks++; if (rx_throughput !== 32'd640) begin errors++; $display("FAIL b2b_thr: got %0d expected 640", rx_throughput); end
   endtask

   task automatic test_bad_frames();
      int p0;
      close_window();
      for (int k = 1; k <= 4; k++) begin
         p0 = pulse_cnt;
         if (k == 4) build_frame(0, 40, 32'h00001000, 32'h01020304, 0);
         else        build_frame(0, 64, 32'h00001000, 32'h01020304, k);
         drive_words(-1);
         checks++;
         if (pulse_cnt !== p0) begin errors++; $display("FAIL bad_%0d_pulse: got %0d expected 0", k, pulse_cnt - p0); end
      end
      checks++; if (rx_ipv4_ip === 32'h01020304) begin errors++; $display("FAIL bad_ip: got %h expected not 01020304", rx_ipv4_ip); end
      close_window();
      checks++; if (rx_pps !== 32'd0) begin errors++; $display("FAIL bad_pps: got %0d expected 0", rx_pps); end
      checks++; if (rx_throughput !== 32'd0) begin errors++; $display("FAIL bad_thr: got %0d expected 0", rx_throughput); end
   endtask

   task automatic test_latency_wrap();
      global_counter = 32'h00000010;
      build_frame(0, 64, 32'hFFFFFF00, 32'hAC100001, 0);
      drive_words(-1);
      checks++; if (rx_latency !== 24'h000110) begin errors++; $display("FAIL wrap_latency: got %h expected 000110", rx_latency); end
      global_counter = 32'h01000000;
      build_frame(0, 61, 32'h00000000, 32'hAC100002, 0);
      drive_words(-1);
      checks++; if (rx_latency !== 24'hFFFFFF) begin errors++; $display("FAIL sat_latency: got %h expected ffffff", rx_latency); end
      checks++; if (rx_ipv4_ip !== 32'hAC100002) begin errors++; $display("FAIL sat_ip: got %h expected ac100002", rx_ipv4_ip); end
      close_window();
      checks++; if (rx_pps !== 32'd2) begin errors++; $display("FAIL odd_pps: got %0d expected 2", rx_pps); end
      checks++; if (rx_throughput !== 32'd125) begin errors++; $display("FAIL odd_thr: got %0d expected 125", rx_throughput); end
   endtask

   task automatic test_coincident();
      int p0;
      global_counter = 32'h00002000;
      close_window();
      build_frame(0, 64, 32'h00001F00, 32'h0B000001, 0);
      build_frame(0, 64, 32'h00001F00, 32'h0B000002, 0);
      drive_words(-1);
      p0 = pulse_cnt;
      // Terminate of this frame is raw word 9; word 10 carries the window close
      build_frame(0, 64, 32'h00001F00, 32'h0B000003, 0);
      drive_words(10);
      checks++; if (pulse_cnt !== p0 + 1) begin errors++; $display("FAIL coin_pulse: got %0d expected 1", pulse_cnt - p0); end
      checks++; if (rx_pps !== 32'd2) begin errors++; $display("FAIL coin_pps_old: got %0d expected 2", rx_pps); end
      checks++; if (rx_throughput !== 32'd128) begin errors++; $display("FAIL coin_thr_old: got %0d expected 128", rx_throughput); end
      close_window();
      checks++; if (rx_pps !== 32'd1) begin errors++; $display("FAIL coin_pps_new: got %0d expected 1", rx_pps); end
      checks++; if (rx_throughput !== 32'd64) begin errors++; $display("FAIL coin_thr_new: got %0d expected 64", rx_throughput); end
   endtask

   task automatic test_reset_mid_frame();
      int p0;
      int n;
      build_frame(0, 64, 32'h00001F00, 32'h0C000001, 0);
      for (int i = 0; i < 5; i++) begin
         @(negedge sys_clk);
         xgmii_rxd = wq_d.pop_front();
         xgmii_rxc = wq_c.pop_front();
      end
      #1 sys_rst_n = 1'b0;
      #1;
      checks++; if (rx_pps !== 32'h0) begin errors++; $display("FAIL rstmid_pps: got %h expected 0", rx_pps); end
      checks++; if (rx_throughput !== 32'h0) begin errors++; $display("FAIL rstmid_thr: got %h expected 0", rx_throughput); end
      checks++; if (rx_latency !== 24'h0) begin errors++; $display("FAIL rstmid_lat: got %h expected 0", rx_latency); end
      checks++; if (rx_ipv4_ip !== 32'h0) begin errors++; $display("FAIL rstmid_ip: got %h expected 0", rx_ipv4_ip); end
      @(negedge sys_clk);
      sys_rst_n = 1'b1;
      p0 = pulse_cnt;
      n = wq_d.size();
      for (int i = 0; i < n; i++) begin
         @(negedge sys_clk);
         xgmii_rxd = wq_d.pop_front();
         xgmii_rxc = wq_c.pop_front();
      end
      @(negedge sys_clk);
      xgmii_rxd = {8{8'h07}};
      xgmii_rxc = 8'hFF;
      repeat (5) @(negedge sys_clk);
      checks++; if (pulse_cnt !== p0) begin errors++; $display("FAIL rstmid_pulse: got %0d expected 0", pulse_cnt - p0); end
      checks++; if (rx_latency !== 24'h0) begin errors++; $display("FAIL rstmid_lat_after: got %h expected 0", rx_latency); end
   endtask

   initial begin
      test_reset();
      test_lane0();
      test_lane4_back_to_back();
      test_bad_frames();
      test_latency_wrap();
      test_coincident();
      test_reset_mid_frame();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
